mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit-block main memory between the instruction cache (read-only) and the data cache (read refill and dirty write-back).
- Sits between both caches' main-memory ports and the memory model.
- Serialises one block transaction at a time, steers response data to the winning requester, and releases only that requester's busywait.
- Fixed data-side priority by default; round-robin is a compile option.

Parameters:
ADDR_W, 28, block address width ({tag,index}, byte/word offset stripped)
DATA_W, 128, block width in bits

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high
d_read  input  1  dcache block read (refill) request
d_write  input  1  dcache block write-back request
d_address  input  ADDR_W  dcache block address
d_writedata  input  DATA_W  dcache write-back block
d_readdata  output  DATA_W  block returned to dcache
d_busywait  output  1  stall to dcache
i_read  input  1  icache block read request
i_address  input  ADDR_W  icache block address
i_readdata  output  DATA_W  block returned to icache
i_busywait  output  1  stall to icache
mem_read  output  1  read strobe to main memory
mem_write  output  1  write strobe to main memory
mem_address  output  ADDR_W  block address to main memory
mem_writedata  output  DATA_W  write block to main memory
mem_readdata  input  DATA_W  block from main memory
mem_busywait  input  1  main memory busy

Behaviour:
- Reset: asynchronous, active-high.
  - While reset is high: state=IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, d_readdata=i_readdata=0, grant=none, last_grant=ICACHE.
  - Asserting reset mid-transaction drops the memory strobes immediately; the transaction is abandoned.
- Requester busywait (combinational): X_busywait = X_request & ~(state==DONE & grant==X).
  - X_request is d_read|d_write for the dcache and i_read for the icache.
  - Busywait is 0 whenever the requester is idle.
- FSM states: IDLE, SERV_D, SERV_I, DONE.
- IDLE:
  - At posedge with a request present, pick the winner.
  - Register opcode, address and writedata into the mem_* outputs; mem_read/mem_write go high after that edge.
  - Go to SERV_D or SERV_I.
  - With no request, stay in IDLE with strobes low.
- Default priority: dcache wins when both request at the same edge.
- d_read and d_write both high is a protocol violation: write wins.
- SERV_x:
  - mem_* outputs held stable.
  - mem_busywait is ignored on the first posedge after entry (memory busywait rises one cycle late).
  - On any later posedge with mem_busywait=0:
    - for a read, latch mem_readdata into x_readdata;
    - clear mem_read/mem_write;
    - go to DONE.
  - The non-granted requester stays stalled throughout.
- DONE: lasts exactly 1 cycle.
  - The winner's busywait is low and its x_readdata is valid (held until the next read completion for that port).
  - The cache samples the data and drops its request at this edge.
  - Next state is IDLE.
- Minimum latency, request to busywait low: 3 cycles (IDLE→SERV→SERV→DONE with memory ready immediately). General latency: 2 + memory busy cycles.
- A request dropped during SERV: the memory transaction still completes. DONE is still entered; the response is written but unused.
- Back-to-back: the loser's pending request is granted from the IDLE cycle following DONE. There is no bubble beyond that IDLE edge.
- Writes never update x_readdata.
- last_grant updates on every IDLE→SERV transition.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the winner is the requester opposite last_grant (strict alternation under contention). A single requester is always granted.
- Undefined: fixed dcache priority. last_grant is still maintained but does not affect selection.

Test Plan:
- Reset then i_read=1, i_address=28'h0000010, memory returns 128'hA5...A5 after 4 busy cycles → mem_read=1 with address 0x10, i_busywait low for exactly the DONE cycle, i_readdata=128'hA5...A5, d_busywait stays 0.
- d_write=1, d_address=28'h0000234, d_writedata=128'h1234 → mem_write=1, mem_writedata=128'h1234, mem_address 0x234, d_readdata unchanged, DONE after memory releases.
- d_read and i_read asserted on the same edge (macro off) → dcache served first, icache granted on the IDLE edge after DONE; i_busywait high throughout the dcache transaction.
- Same as previous with ARB_ROUND_ROBIN_EN defined and last_grant=DCACHE → icache served first, then dcache; repeat three times → grants alternate I,D,I,D,...
- Reset asserted during SERV_D with mem_read=1 → mem_read drops asynchronously, state IDLE, d_busywait=d_read (still stalling); after reset release the request is re-issued and completes normally.
- d_read held and dropped mid-SERV → memory read completes, DONE entered for one cycle, next state IDLE, no grant to the dcache without a new request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Block-level arbiter sharing one main-memory port between the icache and the dcache.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants under contention (default: dcache priority).
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  // state  | meaning
  // IDLE   | no transaction, choose a winner at the next edge
  // SERV_D | memory transaction in flight for the dcache
  // SERV_I | memory transaction in flight for the icache
  // DONE   | single cycle where the winner's busywait is released
  typedef enum logic [1:0] {IDLE = 2'd0, SERV_D = 2'd1, SERV_I = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {GRANT_NONE = 2'd0, GRANT_D = 2'd1, GRANT_I = 2'd2} grant_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t state, state_next;
  grant_t grant;
  logic   last_grant;
  logic   serv_first;
  logic   d_req, i_req, pick_d;

  assign d_req = d_read | d_write;
  assign i_req = i_read;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    pick_d = d_req & (~i_req | (last_grant == LAST_I));
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    pick_d = d_req;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory busywait rises one cycle late, so the first edge in SERV is never a completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_d)     state_next = SERV_D;
        else if (i_req) state_next = SERV_I;
      end
      SERV_D, SERV_I: begin
        if (!serv_first && !mem_busywait) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    d_busywait = d_req & ~((state == DONE) & (grant == GRANT_D));
    i_busywait = i_req & ~((state == DONE) & (grant == GRANT_I));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      d_readdata    <= '0;
      i_readdata    <= '0;
      grant         <= GRANT_NONE;
      last_grant    <= LAST_I;
      serv_first    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next == SERV_D) begin
            mem_write     <= d_write;
            mem_read      <= ~d_write;
            mem_address   <= d_address;
            mem_writedata <= d_writedata;
            grant         <= GRANT_D;
            last_grant    <= LAST_D;
            serv_first    <= 1'b1;
          end else if (state_next == SERV_I) begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b1;
            mem_address   <= i_address;
            grant         <= GRANT_I;
            last_grant    <= LAST_I;
            serv_first    <= 1'b1;
          end
        end
        SERV_D, SERV_I: begin
          serv_first <= 1'b0;
          if (state_next == DONE) begin
            if (mem_read) begin
              if (state == SERV_D) d_readdata <= mem_readdata;
              else                 i_readdata <= mem_readdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        DONE:    grant <= GRANT_NONE;
        default: grant <= GRANT_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small busy-cycle memory model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          d_read = 1'b0, d_write = 1'b0, i_read = 1'b0;
  logic [AW-1:0] d_address = '0, i_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata, i_readdata;
  logic          d_busywait, i_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_busywait = 1'b0;

  int checks = 0;
  int passed = 0;
  int busy_n = 0;
  int busy_cnt = 0;
  bit mem_active = 1'b0;
  bit other_ok;
  int n;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory raises busywait one cycle after the strobe, then holds it for busy_n more edges.
  always @(negedge clock) begin
    if (!(mem_read || mem_write)) begin
      mem_active   = 1'b0;
      mem_busywait = 1'b0;
    end else if (!mem_active) begin
      mem_active   = 1'b1;
      busy_cnt     = busy_n;
      mem_busywait = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end else begin
      mem_busywait = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // sel 0: until d_busywait low, 1: until i_busywait low, 2: until mem_read low
  task automatic wait_edges(input int sel, output int cnt);
    logic busy;
    cnt = 0;
    other_ok = 1'b1;
    do begin
      @(posedge clock); #1;
      cnt++;
      if (sel == 0 && i_read && !i_busywait) other_ok = 1'b0;
      if (sel == 1 && (d_read || d_write) && !d_busywait) other_ok = 1'b0;
      busy = (sel == 0) ? d_busywait : (sel == 1) ? i_busywait : mem_read;
    end while (busy && cnt < 30);
  endtask

  task automatic contention_round(input int r);
    bit            first_d;
    logic [DW-1:0] data_a, data_b;
    first_d = !RR;
    data_a  = {8{16'h1000 + 16'(r)}};
    data_b  = {8{16'h2000 + 16'(r)}};
    @(negedge clock);
    d_read = 1'b1; d_address = 28'h0000055;
    i_read = 1'b1; i_address = 28'h0000066;
    busy_n = 1; mem_readdata = data_a;
    @(posedge clock); #1;
    check("rr_first_addr", DW'(mem_address), DW'(first_d ? 28'h0000055 : 28'h0000066));
    wait_edges(first_d ? 0 : 1, n);
    check("rr_first_lat", DW'(n), DW'(3));
    check("rr_loser_stalled", DW'(other_ok), DW'(1));
    check("rr_first_data", first_d ? d_readdata : i_readdata, data_a);
    if (first_d) d_read = 1'b0; else i_read = 1'b0;
    mem_readdata = data_b;
    @(posedge clock); #1;
    check("rr_gap_idle", DW'(mem_read), DW'(0));
    @(posedge clock); #1;
    check("rr_second_addr", DW'(mem_address), DW'(first_d ? 28'h0000066 : 28'h0000055));
    wait_edges(first_d ? 1 : 0, n);
    check("rr_second_lat", DW'(n), DW'(3));
    check("rr_second_data", first_d ? i_readdata : d_readdata, data_b);
    if (first_d) i_read = 1'b0; else d_read = 1'b0;
    @(posedge clock);
  endtask

  initial begin
    #12;
    check("rst_mem_read", DW'(mem_read), DW'(0));
    check("rst_mem_write", DW'(mem_write), DW'(0));
    check("rst_mem_address", DW'(mem_address), DW'(0));
    check("rst_readdata", d_readdata | i_readdata, '0);
    @(negedge clock); reset = 1'b0;

    // icache read, 4 busy cycles
    @(negedge clock);
    i_read = 1'b1; i_address = 28'h0000010;
    mem_readdata = {16{8'hA5}}; busy_n = 4;
    #1 check("i_busy_before", DW'(i_busywait), DW'(1));
    @(posedge clock); #1;
    check("i_mem_read", DW'(mem_read), DW'(1));
    check("i_mem_addr", DW'(mem_address), DW'(28'h10));
    wait_edges(1, n);
    check("i_latency", DW'(n), DW'(6));
    check("i_readdata", i_readdata, {16{8'hA5}});
    check("i_d_busy", DW'(d_busywait), DW'(0));
    check("i_strobe_clear", DW'(mem_read), DW'(0));
    @(posedge clock); #1;
    check("i_busy_after_done", DW'(i_busywait), DW'(1));
    i_read = 1'b0;

    // dcache write-back, 2 busy cycles
    @(negedge clock);
    d_write = 1'b1; d_address = 28'h0000234; d_writedata = 128'h1234; busy_n = 2;
    @(posedge clock); #1;
    check("w_mem_write", DW'(mem_write), DW'(1));
    check("w_mem_read", DW'(mem_read), DW'(0));
    check("w_mem_addr", DW'(mem_address), DW'(28'h234));
    check("w_mem_wdata", mem_writedata, 128'h1234);
    wait_edges(0, n);
    check("w_latency", DW'(n), DW'(4));
    check("w_d_readdata", d_readdata, '0);
    d_write = 1'b0;
    @(posedge clock); #1;
    check("w_strobe_clear", DW'(mem_write), DW'(0));

    for (int r = 0; r < 3; r++) contention_round(r);

    // reset in the middle of a dcache read
    @(negedge clock);
    d_read = 1'b1; d_address = 28'h0000077; busy_n = 3; mem_readdata = {4{32'hCAFE0003}};
    @(posedge clock); #1;
    check("rst_mid_strobe", DW'(mem_read), DW'(1));
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("rst_mid_drop", DW'(mem_read), DW'(0));
    check("rst_mid_stall", DW'(d_busywait), DW'(1));
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("rst_reissue", DW'(mem_address), DW'(28'h77));
    wait_edges(0, n);
    check("rst_reissue_lat", DW'(n), DW'(5));
    check("rst_reissue_data", d_readdata, {4{32'hCAFE0003}});
    d_read = 1'b0;
    @(posedge clock);

    // request dropped mid-transaction
    @(negedge clock);
    d_read = 1'b1; d_address = 28'h0000088; busy_n = 3; mem_readdata = {4{32'hBEEF0004}};
    @(posedge clock); #1;
    @(posedge clock); #1;
    d_read = 1'b0;
    #1 check("drop_no_stall", DW'(d_busywait), DW'(0));
    wait_edges(2, n);
    check("drop_lat", DW'(n), DW'(4));
    check("drop_data", d_readdata, {4{32'hBEEF0004}});
    @(posedge clock); #1;
    check("drop_idle1", DW'(mem_read), DW'(0));
    @(posedge clock); #1;
    check("drop_idle2", DW'(mem_read), DW'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
